// File: rtl/dmem_responder.sv
// Data-memory responder: word RAM, console TX FIFO and optional 64-bit machine timer.
// Define DMEM_TIMER_EN to build mtime/mtimecmp and timer_irq; otherwise the timer block reads 0.
module dmem_responder #(
  parameter int unsigned DEPTH     = 4096,
  parameter logic [31:0] MMIO_BASE = 32'h1000_0000,
  parameter int unsigned TX_DEPTH  = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        data_re,
  input  logic [31:0] data_raddr,
  output logic [31:0] data_rdata,
  input  logic        data_we,
  input  logic [31:0] data_waddr,
  input  logic [31:0] data_wdata,
  output logic        tx_valid,
  output logic [7:0]  tx_data,
  input  logic        tx_ready,
  output logic        timer_irq
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = $clog2(TX_DEPTH);
  localparam logic [PW:0] TX_FULL = TX_DEPTH[PW:0];

  typedef enum logic [2:0] {
    REG_TX       = 3'd0,
    REG_STATUS   = 3'd1,
    REG_MTIME_LO = 3'd2,
    REG_MTIME_HI = 3'd3,
    REG_CMP_LO   = 3'd4,
    REG_CMP_HI   = 3'd5,
    REG_NONE     = 3'd7
  } reg_e;

  // Decoding works on word addresses, so byte-lane bits never participate.
  function automatic reg_e decode(input logic [29:0] word);
    logic [29:0] off;
    off = word - MMIO_BASE[31:2];
    if (word < MMIO_BASE[31:2] || off > 30'd5) return REG_NONE;
    return reg_e'(off[2:0]);
  endfunction

  function automatic logic ram_hit(input logic [29:0] word);
    return (word < MMIO_BASE[31:2]) && ((word >> AW) == '0);
  endfunction

  logic [29:0] w_rword, w_wword;
  reg_e        w_rreg, w_wreg;
  logic        w_ram_we, w_push, w_push_ok, w_pop, w_clr, w_empty, w_full;
  logic        w_unused;

  logic [31:0] r_mem [DEPTH];
  logic [7:0]  r_buf [TX_DEPTH];
  logic [PW-1:0] r_rptr, r_wptr;
  logic [PW:0]   r_count;
  logic          r_ovf;

  assign w_rword   = data_raddr[31:2];
  assign w_wword   = data_waddr[31:2];
  assign w_rreg    = decode(w_rword);
  assign w_wreg    = decode(w_wword);
  assign w_ram_we  = data_we && ram_hit(w_wword);
  assign w_push    = data_we && (w_wreg == REG_TX);
  assign w_clr     = data_we && (w_wreg == REG_STATUS) && data_wdata[2];
  assign w_empty   = (r_count == '0);
  assign w_full    = (r_count == TX_FULL);
  assign tx_valid  = !w_empty;
  assign tx_data   = w_empty ? '0 : r_buf[r_rptr];
  assign w_pop     = tx_valid && tx_ready;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
  assign w_push_ok = w_push && (!w_full || w_pop);
  assign w_unused  = &{1'b0, data_raddr[1:0], data_waddr[1:0]};

  always_ff @(posedge clk) begin
    if (w_ram_we) r_mem[data_waddr[AW+1:2]] <= data_wdata;
  end

  always_ff @(posedge clk) begin
    if (w_push_ok) r_buf[r_wptr] <= data_wdata[7:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rptr  <= '0;
      r_wptr  <= '0;
      r_count <= '0;
      r_ovf   <= 1'b0;
    end else begin
      if (w_push_ok) r_wptr <= r_wptr + 1'b1;
      if (w_pop)     r_rptr <= r_rptr + 1'b1;
      case ({w_push_ok, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      if (w_push && w_full && !w_pop) r_ovf <= 1'b1;
      else if (w_clr)                 r_ovf <= 1'b0;
    end
  end

`ifdef DMEM_TIMER_EN
  logic [63:0] r_mtime, r_mtimecmp;
  logic        r_irq;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mtime    <= '0;
      r_mtimecmp <= '1;
      r_irq      <= 1'b0;
    end else begin
      if (data_we && w_wreg == REG_MTIME_LO)      r_mtime[31:0]  <= data_wdata;
      else if (data_we && w_wreg == REG_MTIME_HI) r_mtime[63:32] <= data_wdata;
      else                                        r_mtime        <= r_mtime + 64'd1;
      if (data_we && w_wreg == REG_CMP_LO) r_mtimecmp[31:0]  <= data_wdata;
      if (data_we && w_wreg == REG_CMP_HI) r_mtimecmp[63:32] <= data_wdata;
      r_irq <= (r_mtime >= r_mtimecmp);
    end
  end

  assign timer_irq = r_irq;
`else
  assign timer_irq = 1'b0;
`endif

  always_comb begin
    data_rdata = '0;
    if (data_re) begin
      if (ram_hit(w_rword)) begin
        data_rdata = r_mem[data_raddr[AW+1:2]];
      end else begin
        case (w_rreg)
          REG_STATUS:   data_rdata = {29'b0, r_ovf, w_full, w_empty};
`ifdef DMEM_TIMER_EN
          REG_MTIME_LO: data_rdata = r_mtime[31:0];
          REG_MTIME_HI: data_rdata = r_mtime[63:32];
          REG_CMP_LO:   data_rdata = r_mtimecmp[31:0];
          REG_CMP_HI:   data_rdata = r_mtimecmp[63:32];
`endif
          default:      data_rdata = '0;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: vector table for RAM/decode, hand sequences for FIFO, timer, reset.
module tb_dmem_responder;
  localparam logic [31:0] MB     = 32'h1000_0000;
  localparam logic [31:0] A_TX   = MB;
  localparam logic [31:0] A_ST   = MB + 32'h04;
  localparam logic [31:0] A_MLO  = MB + 32'h08;
  localparam logic [31:0] A_MHI  = MB + 32'h0C;
  localparam logic [31:0] A_CLO  = MB + 32'h10;
  localparam logic [31:0] A_CHI  = MB + 32'h14;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        data_re = 1'b0;
  logic [31:0] data_raddr = '0;
  logic [31:0] data_rdata;
  logic        data_we = 1'b0;
  logic [31:0] data_waddr = '0;
  logic [31:0] data_wdata = '0;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        tx_ready = 1'b0;
  logic        timer_irq;

  int n_chk = 0;
  int n_err = 0;

  dmem_responder #(.DEPTH(4096), .MMIO_BASE(32'h1000_0000), .TX_DEPTH(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .data_re(data_re), .data_raddr(data_raddr), .data_rdata(data_rdata),
    .data_we(data_we), .data_waddr(data_waddr), .data_wdata(data_wdata),
    .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
    .timer_irq(timer_irq)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        we;
    logic [31:0] waddr;
    logic [31:0] wdata;
    logic        re;
    logic [31:0] raddr;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs [15];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    data_we = 1'b1; data_waddr = a; data_wdata = d;
    tick();
    data_we = 1'b0;
  endtask

  task automatic rd(input string name, input logic [31:0] a, input logic [31:0] exp);
    data_re = 1'b1; data_raddr = a;
    #1;
    chk(name, data_rdata, exp);
    data_re = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] exp_q [8];

    vecs[0]  = '{"ram_wr_re0",   1'b1, 32'h10,   32'hDEAD_BEEF, 1'b0, 32'h10,        32'h0};
    vecs[1]  = '{"ram_rd_13",    1'b0, 32'h0,    32'h0,         1'b1, 32'h13,        32'hDEAD_BEEF};
    vecs[2]  = '{"ram_rw_same",  1'b1, 32'h10,   32'h1,         1'b1, 32'h10,        32'hDEAD_BEEF};
    vecs[3]  = '{"ram_rd_new",   1'b0, 32'h0,    32'h0,         1'b1, 32'h10,        32'h1};
    vecs[4]  = '{"ram_oor_rd",   1'b1, 32'h3FFC, 32'hA5A5_0001, 1'b1, 32'h4000,      32'h0};
    vecs[5]  = '{"ram_last",     1'b0, 32'h0,    32'h0,         1'b1, 32'h3FFC,      32'hA5A5_0001};
    vecs[6]  = '{"ram_last_b1",  1'b1, 32'h0,    32'h1111_1111, 1'b1, 32'h3FFD,      32'hA5A5_0001};
    vecs[7]  = '{"unmapped",     1'b1, 32'h4000, 32'h2222_2222, 1'b1, 32'h2000_0000, 32'h0};
    vecs[8]  = '{"ram_oor_wr",   1'b0, 32'h0,    32'h0,         1'b1, 32'h0,         32'h1111_1111};
    vecs[9]  = '{"below_mmio",   1'b0, 32'h0,    32'h0,         1'b1, 32'h0FFF_FFFC, 32'h0};
    vecs[10] = '{"tx_reads0",    1'b0, 32'h0,    32'h0,         1'b1, A_TX,          32'h0};
    vecs[11] = '{"status_rst",   1'b0, 32'h0,    32'h0,         1'b1, A_ST,          32'h1};
    vecs[12] = '{"mmio_hole",    1'b0, 32'h0,    32'h0,         1'b1, MB + 32'h18,   32'h0};
    vecs[13] = '{"re_low",       1'b0, 32'h0,    32'h0,         1'b0, 32'h3FFC,      32'h0};
    vecs[14] = '{"mmio_beyond",  1'b0, 32'h0,    32'h0,         1'b1, MB + 32'h100,  32'h0};

    // Reset state
    #1;
    chk("rst_tx_valid", tx_valid, 0);
    chk("rst_tx_data", tx_data, 0);
    chk("rst_irq", timer_irq, 0);
    chk("rst_rdata", data_rdata, 0);
    #10 rst_n = 1'b1;
    tick();

    // RAM and decode vectors
    for (int unsigned i = 0; i < 15; i++) begin
      data_we = vecs[i].we; data_waddr = vecs[i].waddr; data_wdata = vecs[i].wdata;
      data_re = vecs[i].re; data_raddr = vecs[i].raddr;
      #1;
      chk(vecs[i].name, data_rdata, vecs[i].exp);
      tick();
      data_we = 1'b0; data_re = 1'b0;
    end

    // FIFO fill with sink stalled; first push shows one-cycle latency
    data_we = 1'b1; data_waddr = A_TX; data_wdata = 32'h41;
    #1;
    chk("push_lat_before", tx_valid, 0);
    tick();
    data_we = 1'b0;
    chk("push_lat_after", tx_valid, 1);
    chk("head_first", tx_data, 8'h41);
    for (int unsigned i = 1; i < 8; i++) wr(A_TX, 32'h41 + i);
    rd("status_full", A_ST, 32'h2);
    wr(A_TX, 32'h49);
    rd("status_ovf", A_ST, 32'h6);
    chk("head_after_drop", tx_data, 8'h41);

    tx_ready = 1'b1;
    for (int unsigned i = 0; i < 8; i++) begin
      chk($sformatf("drain_valid_%0d", i), tx_valid, 1);
      chk($sformatf("drain_data_%0d", i), tx_data, 8'h41 + i);
      tick();
    end
    chk("drain_empty", tx_valid, 0);
    tx_ready = 1'b0;
    rd("status_ovf_empty", A_ST, 32'h5);
    wr(A_ST, 32'h3);
    rd("ovf_not_cleared", A_ST, 32'h5);
    wr(A_ST, 32'h4);
    rd("ovf_cleared", A_ST, 32'h1);

    // Full FIFO, simultaneous push and pop
    for (int unsigned i = 0; i < 8; i++) wr(A_TX, 32'h41 + i);
    tx_ready = 1'b1;
    wr(A_TX, 32'h5A);
    tx_ready = 1'b0;
    rd("pushpop_status", A_ST, 32'h2);
    chk("pushpop_head", tx_data, 8'h42);
    for (int unsigned i = 0; i < 7; i++) exp_q[i] = 8'h42 + i[7:0];
    exp_q[7] = 8'h5A;
    tx_ready = 1'b1;
    for (int unsigned i = 0; i < 8; i++) begin
      chk($sformatf("pp_drain_%0d", i), tx_data, exp_q[i]);
      tick();
    end
    chk("pp_empty", tx_valid, 0);
    tx_ready = 1'b0;

`ifdef DMEM_TIMER_EN
    wr(A_CHI, 32'h0);
    wr(A_CLO, 32'd100);
    wr(A_MLO, 32'd90);
    rd("mtime_lo_load", A_MLO, 32'd90);
    for (int unsigned k = 1; k <= 12; k++) begin
      tick();
      chk($sformatf("irq_k%0d", k), timer_irq, (k >= 11) ? 64'd1 : 64'd0);
    end
    wr(A_CLO, 32'hFFFF_FFFF);
    chk("irq_hold", timer_irq, 1);
    tick();
    chk("irq_fall", timer_irq, 0);
    wr(A_MHI, 32'hFFFF_FFFF);
    wr(A_MLO, 32'hFFFF_FFFF);
    rd("wrap_pre_lo", A_MLO, 32'hFFFF_FFFF);
    tick();
    rd("wrap_lo", A_MLO, 32'h0);
    rd("wrap_hi", A_MHI, 32'h0);
`else
    wr(A_CLO, 32'h0);
    wr(A_CHI, 32'h0);
    wr(A_MLO, 32'h5);
    rd("notimer_mlo", A_MLO, 32'h0);
    rd("notimer_clo", A_CLO, 32'h0);
    rd("notimer_chi", A_CHI, 32'h0);
    for (int unsigned k = 0; k < 3; k++) begin
      tick(); tick(); tick();
      chk($sformatf("notimer_irq_%0d", k), timer_irq, 0);
    end
`endif

    // Asynchronous reset with live FIFO entries
    for (int unsigned i = 0; i < 3; i++) wr(A_TX, 32'h61 + i);
`ifdef DMEM_TIMER_EN
    wr(A_CHI, 32'h0);
    wr(A_CLO, 32'h0);
    tick();
    chk("pre_rst_irq", timer_irq, 1);
`endif
    chk("pre_rst_valid", tx_valid, 1);
    #3 rst_n = 1'b0;
    #1;
    chk("arst_valid", tx_valid, 0);
    chk("arst_data", tx_data, 0);
    chk("arst_irq", timer_irq, 0);
    #2 rst_n = 1'b1;
    rd("post_rst_status", A_ST, 32'h1);
`ifdef DMEM_TIMER_EN
    rd("post_rst_mtime0", A_MLO, 32'h0);
`endif
    tick();
`ifdef DMEM_TIMER_EN
    rd("post_rst_mtime1", A_MLO, 32'h1);
    rd("post_rst_cmphi", A_CHI, 32'hFFFF_FFFF);
`endif
    chk("post_rst_valid", tx_valid, 0);
    chk("post_rst_irq", timer_irq, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
